weight_pulse_gen: RTL and testbench
===================================

// Module: weight_pulse_gen
// PURPOSE
//   Transmit side of the car-load interface. Turns the raw car-door entry/exit
//   sensors into the clean edge-driven weight_flip / weight_flip_reset pulses
//   consumed by weight_control.
//   - One weight_flip pulse per passenger boarding.
//   - One weight_flip_reset pulse when the car becomes empty.
//   - Keeps its own occupancy count and queues pulses so no event is lost.
// PARAMETERS
//   DEBOUNCE_CYCLES  4   consecutive stable synchronised samples needed to accept a sensor level change
//   PULSE_HIGH       2   cycles each output pulse is held high
//   PULSE_LOW        2   minimum low cycles after any pulse before the next pulse
//   MAX_OCC          15  occupancy saturation value (occupancy is 4 bits)
// PORTS
//   clk                 in   1  system clock, rising edge
//   reset               in   1  asynchronous, active-high reset
//   enter_raw           in   1  raw entry beam sensor (async, bouncy)
//   exit_raw            in   1  raw exit beam sensor (async, bouncy)
//   weight_flip         out  1  registered boarding pulse to weight_control
//   weight_flip_reset   out  1  registered car-empty pulse to weight_control
//   occupancy           out  4  current passengers in car
//   pending             out  3  weight_flip pulses queued, not yet sent
//   busy                out  1  1 whenever FSM is not IDLE
//   sensor_err          out  1  sticky error flag; cleared only by reset
// BEHAVIOUR
//   Reset (async)
//   - All outputs, occupancy, pending, debounced levels and sensor_err go to 0; FSM goes to IDLE.
//   - Asserting reset mid-pulse drops the pulse immediately.
//   Input conditioning
//   - Each raw input passes through a 2-flop synchroniser.
//   - Debounced level toggles only after the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
//   - A 0->1 transition of the debounced level is one event: enter_ev / exit_ev, single cycle.
//   Event handling (registered, the cycle the event occurs)
//   - enter_ev only: occupancy+1 and pending+1.
//     - At MAX_OCC: occupancy holds and sensor_err sets; pending still increments.
//     - At pending==7: pending holds and sensor_err sets.
//   - exit_ev only, occupancy>1: occupancy-1.
//   - exit_ev only, occupancy==1: occupancy becomes 0, pending clears to 0, rst_req sets.
//   - exit_ev only, occupancy==0: no count change; sensor_err sets.
//   - enter_ev and exit_ev in the same cycle: occupancy unchanged, pending+1, no rst_req.
//   Output FSM: IDLE, FLIP_HI, FLIP_LO, RST_HI, RST_LO
//   - IDLE
//     - rst_req=1 -> RST_HI; rst_req clears.
//     - else pending!=0 -> FLIP_HI; pending decrements by 1.
//     - rst_req has priority over pending.
//   - FLIP_HI: weight_flip=1 for PULSE_HIGH cycles -> FLIP_LO.
//   - RST_HI: weight_flip_reset=1 for PULSE_HIGH cycles -> RST_LO.
//   - FLIP_LO / RST_LO: both outputs 0 for PULSE_LOW cycles -> IDLE.
//   - A pulse in progress always completes HI and LO.
//     - If rst_req arrives during FLIP_HI/FLIP_LO, RST_HI follows the next IDLE cycle.
//   - Enters arriving after rst_req but before RST_HI queue in pending and are sent after the reset pulse.
//   - Latency: an event seen in IDLE makes pending/rst_req nonzero in cycle N, FSM leaves IDLE at N+1, output is high from N+1.
//   - weight_flip and weight_flip_reset are never high in the same cycle.
//   - Period between pulse rising edges is >= PULSE_HIGH+PULSE_LOW+1.
// TESTING
//   1 Reset: assert reset mid-FLIP_HI -> weight_flip=0 in the same cycle; occupancy=0, pending=0, sensor_err=0, busy=0.
//   2 Bounce: enter_raw toggles every cycle for 10 cycles, then stays high.
//     -> exactly one weight_flip, occupancy=1; a glitch shorter than 4 cycles gives no event.
//   3 Burst: 3 enters spaced 5 cycles apart with defaults.
//     -> 3 weight_flip pulses, each 2 cycles high, >=2 cycles low between; pending peaks at 2 (or 1 per spacing) and returns to 0.
//   4 Empty: 2 enters then 2 exits, with the last exit issued while pending=1.
//     -> pending cleared, one weight_flip_reset of 2 cycles, occupancy=0.
//   5 Simultaneous: enter_ev and exit_ev in the same cycle at occupancy=3.
//     -> occupancy stays 3, one weight_flip, no weight_flip_reset.
//   6 Errors: exit at occupancy 0, and 16 enters -> sensor_err=1, occupancy=15, and sensor_err stays 1 until reset.

Source files
------------

// File: rtl/weight_pulse_if.sv
// Car-door sensor levels into the pulse generator, and the pulse and status
// outputs toward weight_control.
// Signalling: there is no valid/ready handshake on this bundle. enter_raw and
// exit_raw are asynchronous levels sampled every cycle. weight_flip and
// weight_flip_reset are registered, edge-consumed pulses. The receiver must
// accept every pulse. Pulses are never back to back, so the receiver always
// sees a low gap between them.
interface weight_pulse_if;
  logic       enter_raw;
  logic       exit_raw;
  logic       weight_flip;
  logic       weight_flip_reset;
  logic [3:0] occupancy;
  logic [2:0] pending;
  logic       busy;
  logic       sensor_err;
  logic [2:0] state_dbg;

  modport master (
    output enter_raw, exit_raw,
    input  weight_flip, weight_flip_reset, occupancy, pending, busy,
           sensor_err, state_dbg
  );

  modport slave (
    input  enter_raw, exit_raw,
    output weight_flip, weight_flip_reset, occupancy, pending, busy,
           sensor_err, state_dbg
  );
endinterface

// File: rtl/weight_pulse_gen.sv
// Door-sensor conditioning, occupancy bookkeeping and the weight_flip /
// weight_flip_reset pulse generator for the car-load interface.
module weight_pulse_gen #(
  parameter int         DEBOUNCE_CYCLES = 4,
  parameter int         PULSE_HIGH      = 2,
  parameter int         PULSE_LOW       = 2,
  parameter logic [3:0] MAX_OCC         = 4'd15
) (
  input logic           clk,
  input logic           reset,
  weight_pulse_if.slave bus
);
  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_FLIP_HI = 3'd1;
  localparam logic [2:0] S_FLIP_LO = 3'd2;
  localparam logic [2:0] S_RST_HI  = 3'd3;
  localparam logic [2:0] S_RST_LO  = 3'd4;

  localparam int            DW      = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam int            TW      =
    $clog2((PULSE_HIGH > PULSE_LOW ? PULSE_HIGH : PULSE_LOW) + 1);
  localparam logic [TW-1:0] HI_LAST = TW'(PULSE_HIGH - 1);
  localparam logic [TW-1:0] LO_LAST = TW'(PULSE_LOW - 1);

  // Bit 0 is the entry channel and bit 1 is the exit channel.
  logic [1:0]          raw;
  logic [1:0]          sync1_q, sync2_q;
  logic [1:0]          db_q, db_d, db_dly_q;
  logic [1:0][DW-1:0]  db_cnt_q, db_cnt_d;
  logic                enter_ev, exit_ev;

  logic [2:0]          state_q, state_d;
  logic [TW-1:0]       tmr_q, tmr_d;
  logic                launch_flip, launch_rst;
  logic [3:0]          occ_q, occ_d;
  logic [2:0]          pend_q, pend_d;
  logic                rst_req_q, rst_req_d;
  logic                err_q, err_d;
  logic                flip_q, flip_d;
  logic                frst_q, frst_d;

  assign raw      = {bus.exit_raw, bus.enter_raw};
  assign enter_ev = db_q[0] & ~db_dly_q[0];
  assign exit_ev  = db_q[1] & ~db_dly_q[1];

  // Debounce: flip the accepted level after enough consecutive differing samples.
  always_comb begin
    db_d     = db_q;
    db_cnt_d = db_cnt_q;
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != db_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          db_d[i]     = ~db_q[i];
          db_cnt_d[i] = '0;
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DW'(1);
        end
      end else begin
        db_cnt_d[i] = '0;
      end
    end
  end

  // Pulse FSM: a started pulse always runs its full high and low phases.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    launch_flip = 1'b0;
    launch_rst  = 1'b0;
    case (state_q)
      S_IDLE: begin
        tmr_d = '0;
        if (rst_req_q) begin
          state_d    = S_RST_HI;
          launch_rst = 1'b1;
        end else if (pend_q != 3'd0) begin
          state_d     = S_FLIP_HI;
          launch_flip = 1'b1;
        end
      end
      S_FLIP_HI, S_RST_HI: begin
        if (tmr_q == HI_LAST) begin
          state_d = (state_q == S_FLIP_HI) ? S_FLIP_LO : S_RST_LO;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      S_FLIP_LO, S_RST_LO: begin
        if (tmr_q == LO_LAST) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Occupancy, queue and error bookkeeping. Event updates override the FSM's dequeue.
  always_comb begin
    occ_d     = occ_q;
    pend_d    = pend_q;
    rst_req_d = rst_req_q;
    err_d     = err_q;
    if (launch_rst)  rst_req_d = 1'b0;
    if (launch_flip) pend_d = pend_q - 3'd1;
    if (enter_ev) begin
      // A full queue drops the boarding and flags it.
      if (pend_q == 3'd7) err_d = 1'b1;
      else                pend_d = pend_d + 3'd1;
      if (!exit_ev) begin
        if (occ_q == MAX_OCC) err_d = 1'b1;
        else                  occ_d = occ_q + 4'd1;
      end
    end else if (exit_ev) begin
      if (occ_q > 4'd1) begin
        occ_d = occ_q - 4'd1;
      end else if (occ_q == 4'd1) begin
        occ_d     = 4'd0;
        pend_d    = 3'd0;
        rst_req_d = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    flip_d = (state_d == S_FLIP_HI);
    frst_d = (state_d == S_RST_HI);
  end

  // All state registers. Reset clears pulses immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      db_q      <= '0;
      db_dly_q  <= '0;
      db_cnt_q  <= '0;
      state_q   <= S_IDLE;
      tmr_q     <= '0;
      occ_q     <= '0;
      pend_q    <= '0;
      rst_req_q <= 1'b0;
      err_q     <= 1'b0;
      flip_q    <= 1'b0;
      frst_q    <= 1'b0;
    end else begin
      sync1_q   <= raw;
      sync2_q   <= sync1_q;
      db_q      <= db_d;
      db_dly_q  <= db_q;
      db_cnt_q  <= db_cnt_d;
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      occ_q     <= occ_d;
      pend_q    <= pend_d;
      rst_req_q <= rst_req_d;
      err_q     <= err_d;
      flip_q    <= flip_d;
      frst_q    <= frst_d;
    end
  end

  assign bus.weight_flip       = flip_q;
  assign bus.weight_flip_reset = frst_q;
  assign bus.occupancy         = occ_q;
  assign bus.pending           = pend_q;
  assign bus.busy              = (state_q != S_IDLE);
  assign bus.sensor_err        = err_q;
  assign bus.state_dbg         = state_q;
endmodule

// File: tb/tb_weight_pulse_gen.sv
// Bench for weight_pulse_gen. A reference model is built from the behavioural
// rules: the debounced level follows the last N synchronised samples, there is
// integer bookkeeping for occupancy and the queue, and each pulse is a
// kind/age window.
module tb_weight_pulse_gen;
  localparam int DB = 4;
  localparam int PH = 2;
  localparam int PL = 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  weight_pulse_if bus();
  weight_pulse_gen dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int n_flip, n_rst, pend_peak;
  bit flip_prev, rst_prev;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // reference model
  int m_occ, m_pend, m_rst_req, m_err;
  int m_kind, m_age;              // kind: 0 none, 1 flip pulse, 2 reset pulse
  bit m_s1[2], m_s2[2], m_db[2], m_db_prev[2];
  bit hist_e[$], hist_x[$];

  function automatic bit all_differ(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    for (int i = q.size() - DB; i < q.size(); i++)
      if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic m_init();
    m_occ = 0; m_pend = 0; m_rst_req = 0; m_err = 0; m_kind = 0; m_age = 0;
    for (int i = 0; i < 2; i++) begin
      m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_db_prev[i] = 0;
    end
    hist_e.delete(); hist_x.delete();
  endtask

  task automatic m_step();
    bit ev_e, ev_x;
    int p0, o0;
    ev_e = m_db[0] && !m_db_prev[0];
    ev_x = m_db[1] && !m_db_prev[1];
    p0 = m_pend; o0 = m_occ;
    if (m_kind == 0) begin
      if (m_rst_req != 0) begin m_kind = 2; m_age = 0; m_rst_req = 0; end
      else if (m_pend > 0) begin m_kind = 1; m_age = 0; m_pend--; end
    end else begin
      m_age++;
      if (m_age == PH + PL) m_kind = 0;
    end
    if (ev_e) begin
      if (p0 == 7) m_err = 1; else m_pend++;
      if (!ev_x) begin
        if (o0 == 15) m_err = 1; else m_occ++;
      end
    end else if (ev_x) begin
      if (o0 > 1) m_occ--;
      else if (o0 == 1) begin m_occ = 0; m_pend = 0; m_rst_req = 1; end
      else m_err = 1;
    end
    hist_e.push_back(m_s2[0]); if (hist_e.size() > DB) void'(hist_e.pop_front());
    hist_x.push_back(m_s2[1]); if (hist_x.size() > DB) void'(hist_x.pop_front());
    m_db_prev[0] = m_db[0]; m_db_prev[1] = m_db[1];
    if (all_differ(hist_e, m_db[0])) m_db[0] = !m_db[0];
    if (all_differ(hist_x, m_db[1])) m_db[1] = !m_db[1];
    m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
    m_s1[0] = bus.enter_raw; m_s1[1] = bus.exit_raw;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) m_init();
    else       m_step();
  end

  // compare process and pulse monitors (outputs sampled on the falling edge)
  always @(negedge clk) begin
    if (!reset) begin
      check("weight_flip", bus.weight_flip, (m_kind == 1 && m_age < PH) ? 1 : 0);
      check("weight_flip_reset", bus.weight_flip_reset, (m_kind == 2 && m_age < PH) ? 1 : 0);
      check("occupancy", bus.occupancy, m_occ);
      check("pending", bus.pending, m_pend);
      check("busy", bus.busy, (m_kind != 0) ? 1 : 0);
      check("sensor_err", bus.sensor_err, m_err);
      check("pulse_exclusive", (bus.weight_flip && bus.weight_flip_reset) ? 1 : 0, 0);
      if (bus.weight_flip && !flip_prev) n_flip++;
      if (bus.weight_flip_reset && !rst_prev) n_rst++;
      if (int'(bus.pending) > pend_peak) pend_peak = bus.pending;
    end
    flip_prev = bus.weight_flip;
    rst_prev  = bus.weight_flip_reset;
  end

  // driver tasks
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; bus.enter_raw = 1'b0; bus.exit_raw = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    n_flip = 0; n_rst = 0; pend_peak = 0;
  endtask

  task automatic pulse_enter(input int hi, input int lo);
    @(negedge clk) bus.enter_raw = 1'b1;
    repeat (hi) @(negedge clk);
    bus.enter_raw = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic pulse_exit(input int hi, input int lo);
    @(negedge clk) bus.exit_raw = 1'b1;
    repeat (hi) @(negedge clk);
    bus.exit_raw = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_idle();
    int n;
    repeat (10) @(negedge clk);
    n = 0;
    while ((m_kind != 0 || m_pend != 0 || m_rst_req != 0) && n < 300) begin
      @(negedge clk); n++;
    end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout model still busy after %0d cycles", n);
    end
  endtask

  initial begin
    int e_cnt, x_cnt, k;
    reset = 1'b1; bus.enter_raw = 1'b0; bus.exit_raw = 1'b0;
    n_flip = 0; n_rst = 0; pend_peak = 0;
    repeat (2) @(negedge clk);
    check("reset_occupancy", bus.occupancy, 0);
    check("reset_pending", bus.pending, 0);
    check("reset_busy", bus.busy, 0);
    check("reset_err", bus.sensor_err, 0);
    check("reset_flip", bus.weight_flip, 0);
    reset = 1'b0;

    // 1: reset asserted while weight_flip is high drops it at once
    @(negedge clk) bus.enter_raw = 1'b1;
    k = 0;
    while (!bus.weight_flip && k < 40) begin @(negedge clk); k++; end
    check("t1_flip_seen", bus.weight_flip, 1);
    #1 reset = 1'b1;
    #1;
    check("t1_flip_dropped", bus.weight_flip, 0);
    check("t1_occupancy", bus.occupancy, 0);
    check("t1_pending", bus.pending, 0);
    check("t1_err", bus.sensor_err, 0);
    check("t1_busy", bus.busy, 0);
    do_reset();

    // 2: bounce gives one event, a short glitch gives none
    for (int i = 0; i < 10; i++) @(negedge clk) bus.enter_raw = ~bus.enter_raw;
    @(negedge clk) bus.enter_raw = 1'b1;
    repeat (12) @(negedge clk);
    bus.enter_raw = 1'b0;
    wait_idle();
    check("t2_flips", n_flip, 1);
    check("t2_occupancy", bus.occupancy, 1);
    pulse_exit(3, 10);
    wait_idle();
    check("t2_glitch_occ", bus.occupancy, 1);
    check("t2_glitch_rst", n_rst, 0);

    // 3: burst of three boardings
    do_reset();
    for (int i = 0; i < 3; i++) pulse_enter(5, 5);
    wait_idle();
    check("t3_flips", n_flip, 3);
    check("t3_occupancy", bus.occupancy, 3);
    check("t3_pending_peak", pend_peak, 1);
    check("t3_pending_end", bus.pending, 0);

    // 4: exit lands while pending is 1 -> queue cleared, one reset pulse
    do_reset();
    @(negedge clk) bus.enter_raw = 1'b1;
    @(negedge clk) bus.exit_raw = 1'b1;
    repeat (6) @(negedge clk);
    bus.enter_raw = 1'b0; bus.exit_raw = 1'b0;
    wait_idle();
    check("t4_flips", n_flip, 1);
    check("t4_resets", n_rst, 1);
    check("t4_occupancy", bus.occupancy, 0);
    check("t4_pending", bus.pending, 0);

    // 5: simultaneous entry and exit at occupancy 3
    do_reset();
    for (int i = 0; i < 3; i++) pulse_enter(5, 5);
    wait_idle();
    n_flip = 0;
    @(negedge clk) begin bus.enter_raw = 1'b1; bus.exit_raw = 1'b1; end
    repeat (5) @(negedge clk);
    bus.enter_raw = 1'b0; bus.exit_raw = 1'b0;
    wait_idle();
    check("t5_occupancy", bus.occupancy, 3);
    check("t5_flips", n_flip, 1);
    check("t5_resets", n_rst, 0);

    // 6: exit on empty car and overfill both flag sensor_err
    do_reset();
    pulse_exit(5, 5);
    wait_idle();
    check("t6_err_underflow", bus.sensor_err, 1);
    check("t6_occ_zero", bus.occupancy, 0);
    for (int i = 0; i < 16; i++) pulse_enter(5, 5);
    wait_idle();
    check("t6_occ_sat", bus.occupancy, 15);
    check("t6_flips", n_flip, 16);
    repeat (20) @(negedge clk);
    check("t6_err_sticky", bus.sensor_err, 1);
    do_reset();
    check("t6_err_cleared", bus.sensor_err, 0);

    // randomized sensor activity against the model
    e_cnt = 0; x_cnt = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if (e_cnt == 0) begin
        bus.enter_raw = ~bus.enter_raw;
        e_cnt = $urandom_range(1, 12);
      end else e_cnt--;
      if (x_cnt == 0) begin
        bus.exit_raw = ~bus.exit_raw;
        x_cnt = $urandom_range(1, 20);
      end else x_cnt--;
    end
    bus.enter_raw = 1'b0; bus.exit_raw = 1'b0;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
